// File: rtl/sequence_frame_transmitter.sv
// Serial frame transmitter: sync pattern, payload MSB first, even parity, then a forced-0 gap.
// Handshake: a word transfers on a rising edge where up_valid && up_ready; up_ready is high only in IDLE.
module sequence_frame_transmitter #(
    parameter int                DATA_W = 8,
    parameter int                SYNC_W = 6,
    parameter logic [SYNC_W-1:0] SYNC   = 6'b110011,
    parameter int                GAP    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              up_valid,
    input  logic [DATA_W-1:0] up_data,
    output logic              up_ready,
    output logic              a,
    output logic              busy,
    output logic              frame_start,
    output logic              frame_done
);

    localparam int MAX_A = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
    localparam int MAX_B = (GAP > MAX_A) ? GAP : MAX_A;
    localparam int MAX_C = (MAX_B > 1) ? MAX_B : 1;
    localparam int CNT_W = $clog2(MAX_C) + 1;

    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [2:0] {IDLE, SYNC_ST, DATA_ST, PARITY, GAP_ST} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [SYNC_W-1:0]   sync_q, sync_d;
    logic                par_q, par_d;
    logic                a_q, a_d;
    logic                frame_start_q, frame_start_d;
    logic                frame_done_q, frame_done_d;

    // a_d is the bit the line carries in the state being entered, so a stays registered.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        shift_d       = shift_q;
        sync_d        = sync_q;
        par_d         = par_q;
        a_d           = 1'b0;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (up_valid) begin
                    shift_d       = up_data;
                    par_d         = ^up_data;
                    sync_d        = SYNC << 1;
                    a_d           = SYNC[SYNC_W-1];
                    frame_start_d = 1'b1;
                    cnt_d         = '0;
                    state_d       = SYNC_ST;
                end
            end
            SYNC_ST: begin
                if (cnt_q == SYNC_LAST) begin
                    a_d     = shift_q[DATA_W-1];
                    shift_d = shift_q << 1;
                    cnt_d   = '0;
                    state_d = DATA_ST;
                end else begin
                    a_d    = sync_q[SYNC_W-1];
                    sync_d = sync_q << 1;
                    cnt_d  = cnt_q + CNT_W'(1);
                end
            end
            DATA_ST: begin
                if (cnt_q == DATA_LAST) begin
                    a_d          = par_q;
                    frame_done_d = 1'b1;
                    cnt_d        = '0;
                    state_d      = PARITY;
                end else begin
                    a_d     = shift_q[DATA_W-1];
                    shift_d = shift_q << 1;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            PARITY: begin
                cnt_d   = '0;
                state_d = (GAP > 0) ? GAP_ST : IDLE;
            end
            GAP_ST: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            shift_q       <= '0;
            sync_q        <= '0;
            par_q         <= 1'b0;
            a_q           <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shift_q       <= shift_d;
            sync_q        <= sync_d;
            par_q         <= par_d;
            a_q           <= a_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign up_ready    = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign a           = a_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;

endmodule
